uart_tx_fsm: RTL and testbench
==============================

UART_TX_FSM -- requirements
Module: uart_tx_fsm

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, setting the data bits per frame; only 8 is supported, to match the 8-bit serializer.
REQ-002 The block SHALL have port clk, input, 1 bit: clock; one UART bit time per clk cycle.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port data_valid, input, 1 bit: upstream byte available.
REQ-005 The block SHALL have port p_data, input, DATA_WIDTH bits: upstream byte, used for parity.
REQ-006 The block SHALL have port par_en, input, 1 bit: 1 inserts a parity bit.
REQ-007 The block SHALL have port par_typ, input, 1 bit: 0 selects even parity, 1 selects odd parity.
REQ-008 The block SHALL have port ser_data, input, 1 bit: serial data from the serializer s_output.
REQ-009 The block SHALL have port ser_bit_no, input, 4 bits: bit counter from the serializer.
REQ-010 The block SHALL have port ser_load, output, 1 bit: load strobe to the serializer.
REQ-011 The block SHALL have port tx_out, output, 1 bit: UART line.
REQ-012 The block SHALL have port busy, output, 1 bit: frame in progress.
REQ-013 The block SHALL have port ready, output, 1 bit: able to accept a byte this cycle.

Function
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY and STOP, held in a registered state.
REQ-015 Transfer SHALL occur when data_valid=1 and ready=1; ready SHALL be 1 in IDLE and STOP only, and combinational from state.
REQ-016 ser_load SHALL equal data_valid AND ready (Mealy), so the serializer loads p_data in the acceptance cycle T0.
REQ-017 At transfer, the block SHALL register par_en, par_typ and parity_bit = (XOR of p_data) XOR par_typ; these registers SHALL hold for the whole frame, independent of later input changes.
REQ-018 Transitions SHALL be: IDLE or STOP with transfer -> START; STOP without transfer -> IDLE; START -> DATA; DATA with ser_bit_no==8 -> PARITY if latched par_en=1, else STOP; PARITY -> STOP.
REQ-019 The DATA state SHALL span exactly cycles T2..T9 after acceptance, ser_bit_no values 1..8, which gives 8 cycles.
REQ-020 tx_out SHALL be: 1 in IDLE; 0 in START; ser_data in DATA; latched parity_bit in PARITY; 1 in STOP.
REQ-021 Frame length SHALL be 11 cycles with parity (T1..T11) and 10 cycles without (T1..T10); data SHALL be sent LSB first.
REQ-022 busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-023 data_valid in START, DATA or PARITY SHALL be ignored: no ser_load, no change to the latched parity registers.
REQ-024 Back-to-back transfer in STOP SHALL give a new START in the next cycle, with no idle cycle; the minimum frame-to-frame spacing is equal to the frame length.
REQ-025 If ser_bit_no is not 8 by the end of the 8th DATA cycle (serializer fault), the block SHALL still leave DATA after 8 cycles using an internal 3-bit count; ser_bit_no==8 and count==7 SHALL be treated as equivalent exit conditions.
REQ-026 Simultaneous transfer and STOP exit SHALL take priority toward START.
REQ-027 There SHALL be no combinational path from ser_data to ready, busy or ser_load.

Reset
REQ-028 While rst=0, the block SHALL force immediately (asynchronously) and hold: state=IDLE, tx_out=1, busy=0, ser_load=0, ready=0, and parity registers=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame: tx_out returns to 1 without finishing the stop bit, with no partial continuation after release.
REQ-030 In the first clk edge after rst rises, the block SHALL be in IDLE and ready=1; a transfer in that cycle SHALL be accepted normally.

Verification
REQ-031 The bench SHALL cover: p_data=0xA5, par_en=1, par_typ=0 -> tx_out over T1..T11 = 0,1,0,1,0,0,1,0,1,0,1; busy high for T1..T11; ser_load high at T0 only.
REQ-032 The bench SHALL cover: p_data=0x01, par_en=1, par_typ=1 -> parity bit at T10 = 0; repeat with par_typ=0 -> parity bit = 1.
REQ-033 The bench SHALL cover: p_data=0xFF, par_en=0 -> 10-cycle frame 0,1,1,1,1,1,1,1,1,1, then IDLE with tx_out=1.
REQ-034 The bench SHALL cover: data_valid held high for two bytes, 0x3C then 0xC3, without parity -> second START at T11 directly after STOP; ser_load pulses at T0 and T10; data_valid during T1..T9 is ignored.
REQ-035 The bench SHALL cover: changing par_typ and p_data during DATA -> parity bit is unchanged from the value latched at T0.
REQ-036 The bench SHALL cover: rst=0 asserted at T5 of a frame -> tx_out=1 and busy=0 within the same cycle; after release, a new byte 0x55 produces a correct full frame.

Source files
------------

// File: rtl/uart_tx_fsm.sv
// rtl/uart_tx_fsm.sv - UART transmit framing FSM driving an external 8-bit serializer
module uart_tx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  ser_data,
    input  logic [3:0]            ser_bit_no,
    output logic                  ser_load,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  ready
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t     state;
    logic [2:0] data_cnt;
    logic       par_en_q;
    logic       par_typ_q;
    logic       data_xor_q;
    logic       xfer;
    logic       data_last;

    // ready is qualified with rst so it reads 0 while reset is held, even though state is IDLE
    assign ready     = rst && ((state == IDLE) || (state == STOP));
    assign xfer      = data_valid && ready;
    assign ser_load  = xfer;
    assign busy      = (state != IDLE);

    // The local count bounds DATA to 8 cycles even if the serializer never reports bit 8
    assign data_last = (ser_bit_no == 4'd8) || (data_cnt == 3'd7);

    always_comb begin
        tx_out = 1'b1;
        case (state)
            IDLE:    tx_out = 1'b1;
            START:   tx_out = 1'b0;
            DATA:    tx_out = ser_data;
            PARITY:  tx_out = data_xor_q ^ par_typ_q;
            STOP:    tx_out = 1'b1;
            default: tx_out = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            data_cnt   <= 3'd0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            data_xor_q <= 1'b0;
        end else begin
            case (state)
                IDLE, STOP: begin
                    if (xfer) begin
                        state      <= START;
                        par_en_q   <= par_en;
                        par_typ_q  <= par_typ;
                        data_xor_q <= ^p_data;
                    end else begin
                        state <= IDLE;
                    end
                end
                START: begin
                    state    <= DATA;
                    data_cnt <= 3'd0;
                end
                DATA: begin
                    data_cnt <= data_cnt + 3'd1;
                    if (data_last) begin
                        state <= par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    state <= STOP;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb/tb_uart_tx_fsm.sv - scoreboard bench for uart_tx_fsm with a behavioural serializer
module tb_uart_tx_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       data_valid;
    logic [7:0] p_data;
    logic       par_en;
    logic       par_typ;
    logic       ser_data;
    logic [3:0] ser_bit_no;
    logic       ser_load;
    logic       tx_out;
    logic       busy;
    logic       ready;

    int total = 0;
    int bad   = 0;
    bit exp_q[$];
    bit fault = 1'b0;

    logic [7:0] sreg = 8'h00;
    logic [3:0] scnt = 4'd8;

    uart_tx_fsm #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .p_data     (p_data),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .ser_data   (ser_data),
        .ser_bit_no (ser_bit_no),
        .ser_load   (ser_load),
        .tx_out     (tx_out),
        .busy       (busy),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    // Serializer: bit_no 1..8 presents bits 0..7 LSB first, starting two cycles after load
    always_ff @(posedge clk) begin
        if (ser_load) begin
            sreg <= p_data;
            scnt <= 4'd0;
        end else if (scnt < 4'd8) begin
            scnt <= scnt + 4'd1;
        end
    end
    assign ser_data   = (scnt >= 4'd1 && scnt <= 4'd8) ? sreg[3'(scnt - 4'd1)] : 1'b1;
    assign ser_bit_no = fault ? 4'd3 : scnt;

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (busy) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL busy_extra: busy=1 with no expected bit at %0t", $time);
                end else begin
                    check("tx_bit", tx_out, exp_q.pop_front());
                end
            end else begin
                check("idle_line", tx_out, 1'b1);
            end
        end
    end

    task automatic push_frame(input logic [10:0] bits, input int len);
        for (int i = len - 1; i >= 0; i--) exp_q.push_back(bits[i]);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ready_wait", ready, 1'b1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_wait", busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after the T1 edge
    task automatic send(input logic [7:0] b, input logic pe, input logic pt,
                        input logic [10:0] bits, input int len, input bit hold);
        wait_ready();
        data_valid = 1'b1;
        p_data     = b;
        par_en     = pe;
        par_typ    = pt;
        push_frame(bits, len);
        #1;
        check("ser_load_t0", ser_load, 1'b1);
        @(posedge clk);
        #1;
        if (!hold) data_valid = 1'b0;
        check("busy_t1", busy, 1'b1);
        check("ser_load_t1", ser_load, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        data_valid = 1'b1;
        p_data     = 8'h00;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        #12;
        check("rst_tx", tx_out, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", ready, 1'b0);
        check("rst_load", ser_load, 1'b0);
        data_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("post_rst_ready", ready, 1'b1);

        // 0xA5 even parity
        send(8'hA5, 1'b1, 1'b0, 11'b01010010101, 11, 1'b0);
        wait_idle();
        // 0x01 odd then even parity
        send(8'h01, 1'b1, 1'b1, 11'b01000000001, 11, 1'b0);
        wait_idle();
        send(8'h01, 1'b1, 1'b0, 11'b01000000011, 11, 1'b0);
        wait_idle();
        // 0xFF no parity
        send(8'hFF, 1'b0, 1'b0, 11'b00111111111, 10, 1'b0);
        wait_idle();
        check("idle_ready", ready, 1'b1);

        // Back-to-back 0x3C then 0xC3 with data_valid held
        send(8'h3C, 1'b0, 1'b0, 11'b00001111001, 10, 1'b1);
        p_data = 8'hC3;
        for (int k = 1; k <= 9; k++) begin
            #1;
            check("ignored_valid", ser_load, 1'b0);
            @(posedge clk);
            #1;
        end
        check("b2b_ready_t10", ready, 1'b1);
        check("b2b_load_t10", ser_load, 1'b1);
        push_frame(11'b00110000111, 10);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        check("b2b_busy_t11", busy, 1'b1);
        wait_idle();

        // Parity latched at T0, inputs changed during DATA
        send(8'h07, 1'b1, 1'b1, 11'b01110000001, 11, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        p_data  = 8'h01;
        par_typ = 1'b0;
        data_valid = 1'b1;
        #1;
        check("data_valid_ignored", ser_load, 1'b0);
        data_valid = 1'b0;
        wait_idle();

        // Serializer never reports bit 8: internal count ends DATA
        fault = 1'b1;
        send(8'h0F, 1'b0, 1'b0, 11'b00111100001, 10, 1'b0);
        wait_idle();
        fault = 1'b0;

        // Reset at T5 aborts the frame, then 0x55 right after release
        send(8'hA5, 1'b1, 1'b0, 11'b01010010101, 11, 1'b0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("abort_tx", tx_out, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_ready", ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("release_ready", ready, 1'b1);
        check("release_busy", busy, 1'b0);
        send(8'h55, 1'b1, 1'b0, 11'b01010101001, 11, 1'b0);
        wait_idle();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: %0d bits left expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
